// File: rtl/conv_window_ctrl.sv
// Raster-scan window controller: counts accepted pixels of an IMG_H x IMG_W frame and
// emits the top-left coordinates of every KERNEL_SIZE window completed on the STRIDE grid.
module conv_window_ctrl #(
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int CNT_BW      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_w_en,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CNT_BW-1:0] o_row,
  output logic [CNT_BW-1:0] o_col,
  output logic              o_last,
  output logic              o_frame_done
);

  localparam int PH_BW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CNT_BW-1:0] W_MAX  = CNT_BW'(IMG_W - 1);
  localparam logic [CNT_BW-1:0] H_MAX  = CNT_BW'(IMG_H - 1);
  localparam logic [CNT_BW-1:0] K_M1   = CNT_BW'(KERNEL_SIZE - 1);
  localparam logic [PH_BW-1:0]  PH_MAX = PH_BW'(STRIDE - 1);

  logic [CNT_BW-1:0] row_q, row_d, col_q, col_d;
  logic [PH_BW-1:0]  rph_q, rph_d, cph_q, cph_d;
  logic [CNT_BW-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic              valid_q, valid_d, last_q, last_d, done_q, done_d;

  logic              accept, col_wrap, row_wrap, last_px, on_grid;
  logic [CNT_BW-1:0] col_nxt, row_nxt;

  // Stride phase restarts where the first window edge lands, then cycles modulo STRIDE.
  function automatic logic [PH_BW-1:0] step_phase(input logic [CNT_BW-1:0] nxt,
                                                  input logic [PH_BW-1:0]  ph);
    if (nxt == K_M1)   return '0;
    if (ph == PH_MAX)  return '0;
    return ph + PH_BW'(1);
  endfunction

  assign o_ready      = !i_w_en && !i_clear && (!valid_q || i_ready);
  assign o_valid      = valid_q;
  assign o_row        = win_row_q;
  assign o_col        = win_col_q;
  assign o_last       = last_q;
  assign o_frame_done = done_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    row_d     = row_q;
    col_d     = col_q;
    rph_d     = rph_q;
    cph_d     = cph_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    valid_d   = valid_q;
    last_d    = last_q;

    accept   = i_valid && o_ready;
    col_wrap = (col_q == W_MAX);
    row_wrap = (row_q == H_MAX);
    last_px  = col_wrap && row_wrap;
    on_grid  = (row_q >= K_M1) && (col_q >= K_M1) && (rph_q == '0) && (cph_q == '0);
    col_nxt  = col_wrap ? '0 : col_q + CNT_BW'(1);
    row_nxt  = row_wrap ? '0 : row_q + CNT_BW'(1);
    done_d   = accept && last_px;

    if (accept) begin
      col_d = col_nxt;
      cph_d = step_phase(col_nxt, cph_q);
      if (col_wrap) begin
        row_d = row_nxt;
        rph_d = step_phase(row_nxt, rph_q);
      end
    end

    // A completing accept can only happen while the output stage is empty or handing off.
    if (accept && on_grid) begin
      valid_d   = 1'b1;
      win_row_d = row_q - K_M1;
      win_col_d = col_q - K_M1;
      last_d    = last_px;
    end else if (i_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (i_clear) begin
      row_d   = '0;
      col_d   = '0;
      rph_d   = '0;
      cph_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all registers sample the same edge.
    if (rst) begin
      row_q     <= '0;
      col_q     <= '0;
      rph_q     <= '0;
      cph_q     <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      rph_q     <= rph_d;
      cph_q     <= cph_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: three geometries, a per-cycle reference model of the
// pixel raster, plus directed checks for latency, backpressure, weight-load freeze, clear and reset.
module tb_conv_window_ctrl;

  logic clk;
  logic rst_w [3];
  logic w_en  [3];
  logic clr   [3];
  logic vld   [3];
  logic rdy_in[3];
  logic o_ready_w[3];
  logic o_valid_w[3];
  logic o_last_w [3];
  logic o_fd_w   [3];
  logic [5:0] o_row_w[3];
  logic [5:0] o_col_w[3];

  int checks   = 0;
  int failures = 0;

  // Reference model state: next pixel coordinates and the expected output register.
  int mr[3], mc[3], erow[3], ecol[3];
  bit ev[3], elast[3], ed[3];
  // Observed handoff statistics.
  int win_cnt[3], last_cnt[3], done_cnt[3], lrow[3], lcol[3];

  conv_window_ctrl #(.IMG_W(32), .IMG_H(32), .KERNEL_SIZE(5), .STRIDE(1), .CNT_BW(6)) u_a (
    .clk(clk), .rst(rst_w[0]), .i_w_en(w_en[0]), .i_clear(clr[0]), .i_valid(vld[0]),
    .o_ready(o_ready_w[0]), .o_valid(o_valid_w[0]), .i_ready(rdy_in[0]),
    .o_row(o_row_w[0]), .o_col(o_col_w[0]), .o_last(o_last_w[0]), .o_frame_done(o_fd_w[0]));

  conv_window_ctrl #(.IMG_W(12), .IMG_H(10), .KERNEL_SIZE(3), .STRIDE(2), .CNT_BW(6)) u_b (
    .clk(clk), .rst(rst_w[1]), .i_w_en(w_en[1]), .i_clear(clr[1]), .i_valid(vld[1]),
    .o_ready(o_ready_w[1]), .o_valid(o_valid_w[1]), .i_ready(rdy_in[1]),
    .o_row(o_row_w[1]), .o_col(o_col_w[1]), .o_last(o_last_w[1]), .o_frame_done(o_fd_w[1]));

  conv_window_ctrl #(.IMG_W(11), .IMG_H(11), .KERNEL_SIZE(3), .STRIDE(2), .CNT_BW(6)) u_c (
    .clk(clk), .rst(rst_w[2]), .i_w_en(w_en[2]), .i_clear(clr[2]), .i_valid(vld[2]),
    .o_ready(o_ready_w[2]), .o_valid(o_valid_w[2]), .i_ready(rdy_in[2]),
    .o_row(o_row_w[2]), .o_col(o_col_w[2]), .o_last(o_last_w[2]), .o_frame_done(o_fd_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare outputs against the model, then advance the model with the inputs of the coming edge.
  task automatic mon(input int id, input int W, input int H, input int K, input int S);
    bit rdy_exp, acc, lastpx;
    check($sformatf("u%0d o_valid", id), 32'(o_valid_w[id]), 32'(ev[id]));
    check($sformatf("u%0d o_frame_done", id), 32'(o_fd_w[id]), 32'(ed[id]));
    if (ev[id]) begin
      check($sformatf("u%0d o_row", id), 32'(o_row_w[id]), erow[id]);
      check($sformatf("u%0d o_col", id), 32'(o_col_w[id]), ecol[id]);
      check($sformatf("u%0d o_last", id), 32'(o_last_w[id]), 32'(elast[id]));
    end
    rdy_exp = !w_en[id] && !clr[id] && (!ev[id] || rdy_in[id]);
    check($sformatf("u%0d o_ready", id), 32'(o_ready_w[id]), 32'(rdy_exp));

    if (o_fd_w[id]) done_cnt[id]++;
    if (o_valid_w[id] && rdy_in[id] && !rst_w[id] && !clr[id]) begin
      win_cnt[id]++;
      if (o_last_w[id]) last_cnt[id]++;
      lrow[id] = 32'(o_row_w[id]);
      lcol[id] = 32'(o_col_w[id]);
    end

    if (rst_w[id] || clr[id]) begin
      mr[id] = 0; mc[id] = 0; ev[id] = 1'b0; elast[id] = 1'b0; ed[id] = 1'b0;
    end else begin
      acc = vld[id] && rdy_exp;
      if (ev[id] && rdy_in[id]) ev[id] = 1'b0;
      lastpx = (mr[id] == H - 1) && (mc[id] == W - 1);
      ed[id] = acc && lastpx;
      if (acc) begin
        if (mr[id] >= K - 1 && mc[id] >= K - 1 &&
            (mr[id] - K + 1) % S == 0 && (mc[id] - K + 1) % S == 0) begin
          ev[id]    = 1'b1;
          erow[id]  = mr[id] - K + 1;
          ecol[id]  = mc[id] - K + 1;
          elast[id] = lastpx;
        end
        if (mc[id] == W - 1) begin
          mc[id] = 0;
          mr[id] = (mr[id] == H - 1) ? 0 : mr[id] + 1;
        end else begin
          mc[id] = mc[id] + 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 32, 32, 5, 1);
    mon(1, 12, 10, 3, 2);
    mon(2, 11, 11, 3, 2);
  end

  task automatic frame_totals(input string tag, input int id, input int sw, input int sd,
                              input int sl, input int exp_w, input int exp_l);
    check({tag, " windows"}, win_cnt[id] - sw, exp_w);
    check({tag, " frame_done"}, done_cnt[id] - sd, 1);
    check({tag, " last"}, last_cnt[id] - sl, exp_l);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sw, sd, sl;
    bit got_done;
    for (int i = 0; i < 3; i++) begin
      rst_w[i] = 1'b1; w_en[i] = 1'b0; clr[i] = 1'b0; vld[i] = 1'b0; rdy_in[i] = 1'b0;
    end
    step(2);
    for (int i = 0; i < 3; i++) rst_w[i] = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset u%0d o_valid", i), 32'(o_valid_w[i]), 0);
      check($sformatf("reset u%0d o_row", i), 32'(o_row_w[i]), 0);
      check($sformatf("reset u%0d o_col", i), 32'(o_col_w[i]), 0);
      check($sformatf("reset u%0d o_last", i), 32'(o_last_w[i]), 0);
      check($sformatf("reset u%0d o_frame_done", i), 32'(o_fd_w[i]), 0);
    end

    // T1: 32x32 K5 S1 full throughput, first window after the 133rd pixel
    sw = win_cnt[0]; sd = done_cnt[0]; sl = last_cnt[0];
    vld[0] = 1'b1; rdy_in[0] = 1'b1;
    step(132);
    check("t1 no window after 132 px", 32'(o_valid_w[0]), 0);
    step(1);
    check("t1 first window valid", 32'(o_valid_w[0]), 1);
    check("t1 first window row", 32'(o_row_w[0]), 0);
    check("t1 first window col", 32'(o_col_w[0]), 0);
    step(1024 - 133);
    vld[0] = 1'b0;
    step(3);
    frame_totals("t1", 0, sw, sd, sl, 784, 1);
    check("t1 last row", lrow[0], 27);
    check("t1 last col", lcol[0], 27);

    // T2: stride 2 geometries; 12x10 ends off grid, 11x11 ends on grid at (8,8)
    vld[1] = 1'b1; rdy_in[1] = 1'b1;
    vld[2] = 1'b1; rdy_in[2] = 1'b1;
    step(120);
    vld[1] = 1'b0;
    step(1);
    vld[2] = 1'b0;
    step(3);
    frame_totals("t2 12x10", 1, 0, 0, 0, 20, 0);
    check("t2 12x10 final row", lrow[1], 6);
    check("t2 12x10 final col", lcol[1], 8);
    frame_totals("t2 11x11", 2, 0, 0, 0, 25, 1);
    check("t2 11x11 final row", lrow[2], 8);
    check("t2 11x11 final col", lcol[2], 8);

    // T3: random backpressure and bursty input
    sw = win_cnt[0]; sd = done_cnt[0]; sl = last_cnt[0];
    got_done = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      vld[0]    = ($urandom_range(0, 3) != 0);
      rdy_in[0] = 1'($urandom_range(0, 1));
      step(1);
      if (o_fd_w[0]) begin
        got_done = 1'b1;
        break;
      end
    end
    vld[0] = 1'b0; rdy_in[0] = 1'b1;
    step(3);
    check("t3 frame finished in budget", 32'(got_done), 1);
    frame_totals("t3", 0, sw, sd, sl, 784, 1);

    // T4: weight load for 20 cycles after pixel 500
    sw = win_cnt[0]; sd = done_cnt[0]; sl = last_cnt[0];
    vld[0] = 1'b1; rdy_in[0] = 1'b1;
    step(500);
    w_en[0] = 1'b1;
    #1;
    check("t4 o_ready during w_en", 32'(o_ready_w[0]), 0);
    step(20);
    check("t4 pending window drained", 32'(o_valid_w[0]), 0);
    w_en[0] = 1'b0;
    step(524);
    vld[0] = 1'b0;
    step(3);
    frame_totals("t4", 0, sw, sd, sl, 784, 1);

    // T5: clear with a window pending, then a full frame
    vld[0] = 1'b1; rdy_in[0] = 1'b1;
    step(300);
    check("t5 pending valid", 32'(o_valid_w[0]), 1);
    check("t5 pending row", 32'(o_row_w[0]), 5);
    check("t5 pending col", 32'(o_col_w[0]), 7);
    rdy_in[0] = 1'b0; clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    check("t5 valid dropped by clear", 32'(o_valid_w[0]), 0);
    sw = win_cnt[0]; sd = done_cnt[0]; sl = last_cnt[0];
    rdy_in[0] = 1'b1;
    step(1024);
    vld[0] = 1'b0;
    step(3);
    frame_totals("t5", 0, sw, sd, sl, 784, 1);

    // T6: reset mid-frame, then a clean frame
    vld[0] = 1'b1; rdy_in[0] = 1'b0;
    step(200);
    check("t6 window held before rst", 32'(o_valid_w[0]), 1);
    rst_w[0] = 1'b1;
    step(1);
    rst_w[0] = 1'b0;
    check("t6 o_valid after rst", 32'(o_valid_w[0]), 0);
    check("t6 o_row after rst", 32'(o_row_w[0]), 0);
    check("t6 o_col after rst", 32'(o_col_w[0]), 0);
    check("t6 o_last after rst", 32'(o_last_w[0]), 0);
    check("t6 o_frame_done after rst", 32'(o_fd_w[0]), 0);
    sw = win_cnt[0]; sd = done_cnt[0]; sl = last_cnt[0];
    rdy_in[0] = 1'b1;
    step(1024);
    vld[0] = 1'b0;
    step(3);
    frame_totals("t6", 0, sw, sd, sl, 784, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
